// File: rtl/tart_axil_pkg.sv
// tart_axil_pkg
// Shared definitions for the TART AXI4-Lite register bank:
//   RESP_OKAY / RESP_SLVERR  - AXI response encodings
//   wr_state_t               - write-channel FSM states
//   rd_state_t               - read-channel FSM states
package tart_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/tart_axil_regbank_if.sv
// tart_axil_regbank_if
// AXI4-Lite bus bundle between the PS interconnect (master) and the
// register bank (slave).
//   aw*  write address channel    w*  write data channel
//   b*   write response channel   ar* read address channel
//   r*   read data channel
interface tart_axil_regbank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/tart_axil_strb_merge.sv
// tart_axil_strb_merge
// Combinational byte-strobe merge: each byte of the result comes from
// wdata when its strobe bit is set, otherwise from the old value.
//   old_val  in   current register contents
//   wdata    in   write data
//   wstrb    in   byte strobes, one per byte lane
//   merged   out  updated register value
module tart_axil_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_val,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   merged
);
    always_comb begin
        merged = old_val;
        for (int k = 0; k < DATA_WIDTH / 8; k++) begin
            if (wstrb[k]) begin
                merged[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: rtl/tart_axil_regbank.sv
// tart_axil_regbank
// AXI4-Lite slave register bank: NUM_RW byte-strobed control registers
// followed by NUM_RO read-only status registers in the word address space.
//   ACLK         in   clock, rising edge
//   ARESET       in   synchronous active-high reset
//   s_axi        slave modport of tart_axil_regbank_if
//   rw_regs      out  control register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rw_wr_pulse  out  one-cycle pulse after register i is written
//   ro_regs      in   status inputs, same packing, sampled on AR acceptance
module tart_axil_regbank
    import tart_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_RW     = 8,
    parameter int NUM_RO     = 8
) (
    input  logic                                          ACLK,
    input  logic                                          ARESET,
    tart_axil_regbank_if.slave                            s_axi,
    output logic [NUM_RW*DATA_WIDTH-1:0]                  rw_regs,
    output logic [NUM_RW-1:0]                             rw_wr_pulse,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] ro_regs
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = (DATA_WIDTH == 64) ? 3 : 2;
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    // Holds readies low for the cycle in which reset is released.
    logic rst_done;

    logic aw_rdy, w_rdy, ar_rdy;
    logic aw_hs, w_hs, ar_hs, commit;

    logic [IDX_W-1:0]      aw_idx_q, wr_idx, ar_idx;
    logic [DATA_WIDTH-1:0] w_data_q, wr_data, wr_old, wr_merged, rd_val;
    logic [STRB_W-1:0]     w_strb_q, wr_strb;
    logic                  wr_is_rw, rd_is_rw, rd_is_ro;

    logic [DATA_WIDTH-1:0] regs [NUM_RW];
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

    // Write channel: AW and W are taken independently; the commit happens on
    // the edge where the second of the pair is accepted.
    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        aw_rdy  = rst_done && (wr_state == WR_IDLE || wr_state == WR_HAVE_W);
        w_rdy   = rst_done && (wr_state == WR_IDLE || wr_state == WR_HAVE_AW);
        aw_hs   = s_axi.awvalid && aw_rdy;
        w_hs    = s_axi.wvalid && w_rdy;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_next = WR_RESP;
                    commit  = 1'b1;
                end else if (aw_hs) begin
                    wr_next = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_hs) begin
                    wr_next = WR_RESP;
                    commit  = 1'b1;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs) begin
                    wr_next = WR_RESP;
                    commit  = 1'b1;
                end
            end
            WR_RESP: begin
                if (s_axi.bready) begin
                    wr_next = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        ar_rdy  = rst_done && (rd_state == RD_IDLE);
        ar_hs   = s_axi.arvalid && ar_rdy;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_RESP;
            RD_RESP: if (s_axi.rready) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            rst_done <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            rst_done <= 1'b1;
        end
    end

    // Whichever half arrived first is taken from its latch; the other comes
    // straight off the bus in the commit cycle.
    always_comb begin
        wr_idx  = (wr_state == WR_HAVE_AW) ? aw_idx_q : s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
        wr_data = (wr_state == WR_HAVE_W) ? w_data_q : s_axi.wdata;
        wr_strb = (wr_state == WR_HAVE_W) ? w_strb_q : s_axi.wstrb;
        wr_is_rw = 32'(wr_idx) < 32'(NUM_RW);
        wr_old  = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (32'(wr_idx) == 32'(i)) wr_old = regs[i];
        end
    end

    tart_axil_strb_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .old_val(wr_old),
        .wdata  (wr_data),
        .wstrb  (wr_strb),
        .merged (wr_merged)
    );

    // Unmapped indices leave rd_val at zero.
    always_comb begin
        ar_idx   = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
        rd_is_rw = 32'(ar_idx) < 32'(NUM_RW);
        rd_is_ro = !rd_is_rw && (32'(ar_idx) < 32'(NUM_RW + NUM_RO));
        rd_val   = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (32'(ar_idx) == 32'(i)) rd_val = regs[i];
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (32'(ar_idx) == 32'(NUM_RW + i)) rd_val = ro_regs[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_hs) aw_idx_q <= s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
        if (w_hs) begin
            w_data_q <= s_axi.wdata;
            w_strb_q <= s_axi.wstrb;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
            rw_wr_pulse <= '0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
        end else begin
            rw_wr_pulse <= '0;
            if (commit) begin
                if (wr_is_rw) begin
                    bresp_q <= RESP_OKAY;
                    for (int i = 0; i < NUM_RW; i++) begin
                        if (32'(wr_idx) == 32'(i)) begin
                            regs[i]        <= wr_merged;
                            rw_wr_pulse[i] <= 1'b1;
                        end
                    end
                end else begin
                    bresp_q <= RESP_SLVERR;
                end
            end
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= (rd_is_rw || rd_is_ro) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_pack
        assign rw_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    assign s_axi.awready = aw_rdy;
    assign s_axi.wready  = w_rdy;
    assign s_axi.bvalid  = (wr_state == WR_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = ar_rdy;
    assign s_axi.rvalid  = (rd_state == RD_RESP);
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
endmodule
